// File: rtl/uart_mini_rx_pkg.sv
// Shared constants for the mini UART receiver: bit period, register map,
// register bit indices and receive FSM states.
package uart_mini_rx_pkg;

    localparam int unsigned SERIAL_WCNT = 16;

    // Register offsets as seen on paddr[3:2]
    localparam logic [1:0] UART_RX_DATA = 2'd0;
    localparam logic [1:0] UART_RX_STAT = 2'd1;
    localparam logic [1:0] UART_RX_CTRL = 2'd2;

    localparam int unsigned STAT_NE    = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_OVR   = 2;
    localparam int unsigned STAT_FRM   = 3;

    localparam int unsigned CTRL_RX_EN      = 0;
    localparam int unsigned CTRL_IRQ_EN     = 1;
    localparam int unsigned CTRL_ERR_IRQ_EN = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: input synchroniser, receive FSM and bit/cycle counters.
// Emits one-cycle byte_valid/frame_err strobes at the stop-bit sample.
module uart_rx_core
    import uart_mini_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = SERIAL_WCNT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       rx_en_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      sync_q;
    logic            rx_prev_q;
    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        if (!rx_en_i) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    // A start needs a fresh falling edge, so a held-low break is seen once
                    if (rx_prev_q && !rx_s) begin
                        state_d = RX_START;
                        cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HalfLast) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BitLast) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BitLast) begin
                        cnt_d        = '0;
                        state_d      = RX_IDLE;
                        byte_valid_o = rx_s;
                        frame_err_o  = ~rx_s;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign byte_data_o = shift_q;

endmodule

// File: rtl/uart_mini_rx.sv
// APB receive UART: byte FIFO, status/control registers and register decode
// around the uart_rx_core deserialiser.
module uart_mini_rx
    import uart_mini_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = SERIAL_WCNT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    input  logic        rx,
    output logic        rts,
    output logic        irq,
    output logic        dreq
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
    localparam logic [LvlW-1:0] LvlRts  = LvlW'(FIFO_DEPTH - 1);

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            ovr_q, ovr_d;
    logic            frm_q, frm_d;
    logic [2:0]      ctrl_q, ctrl_d;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic [1:0] addr_sel;
    logic       wr_acc, rd_acc, empty, full, pop, push_ok, overrun_evt, stat_wr;
    logic       unused_apb;

    assign unused_apb = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata[31:4]};

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .rx_en_i     (ctrl_q[CTRL_RX_EN]),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .frame_err_o (frame_err)
    );

    assign addr_sel = apbs_paddr[3:2];
    assign wr_acc   = apbs_psel & apbs_penable & apbs_pwrite;
    assign rd_acc   = apbs_psel & apbs_penable & ~apbs_pwrite;
    assign empty    = (level_q == '0);
    assign full     = (level_q == LvlFull);
    assign pop      = rd_acc & (addr_sel == UART_RX_DATA) & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign push_ok     = byte_valid & (~full | pop);
    assign overrun_evt = byte_valid & full & ~pop;
    assign stat_wr     = wr_acc & (addr_sel == UART_RX_STAT);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // New errors win over a same-cycle W1C
    always_comb begin
        ovr_d  = overrun_evt | (ovr_q & ~(stat_wr & apbs_pwdata[STAT_OVR]));
        frm_d  = frame_err | (frm_q & ~(stat_wr & apbs_pwdata[STAT_FRM]));
        ctrl_d = ctrl_q;
        if (wr_acc && addr_sel == UART_RX_CTRL) begin
            ctrl_d = apbs_pwdata[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
            frm_q    <= 1'b0;
            ctrl_q   <= 3'b001;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= byte_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
            frm_q    <= frm_d;
            ctrl_q   <= ctrl_d;
        end
    end

    always_comb begin
        apbs_prdata = '0;
        case (addr_sel)
            UART_RX_DATA: begin
                if (!empty) begin
                    apbs_prdata = {23'b0, 1'b1, mem_q[rd_ptr_q]};
                end
            end
            UART_RX_STAT: apbs_prdata = {24'b0, 4'(level_q), frm_q, ovr_q, full, ~empty};
            UART_RX_CTRL: apbs_prdata = {29'b0, ctrl_q};
            default:      apbs_prdata = '0;
        endcase
    end

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign dreq         = ~empty;
    assign rts          = (level_q >= LvlRts);
    assign irq          = (ctrl_q[CTRL_IRQ_EN] & ~empty)
                        | (ctrl_q[CTRL_ERR_IRQ_EN] & (ovr_q | frm_q));

endmodule

// File: tb/tb_uart_mini_rx.sv
// Directed/randomised bench for uart_mini_rx against a queue-based model.
module tb_uart_mini_rx;
    localparam int unsigned Cpb   = 16;
    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        rx = 1'b1;
    logic        rts, irq, dreq;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         ovr_m, frm_m;
    logic [2:0] ctrl_m;

    always #5 clk = ~clk;

    uart_mini_rx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .apbs_psel   (psel),
        .apbs_penable(penable),
        .apbs_pwrite (pwrite),
        .apbs_paddr  (paddr),
        .apbs_pwdata (pwdata),
        .apbs_prdata (prdata),
        .apbs_pready (pready),
        .apbs_pslverr(pslverr),
        .rx          (rx),
        .rts         (rts),
        .irq         (irq),
        .dreq        (dreq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int lvl = exp_q.size();
        return {24'b0, 4'(lvl), 1'(frm_m), 1'(ovr_m), 1'(lvl == Depth), 1'(lvl != 0)};
    endfunction

    function automatic logic [31:0] m_pop();
        logic [31:0] v = 32'h0;
        if (exp_q.size() != 0) v = {23'b0, 1'b1, exp_q.pop_front()};
        return v;
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (exp_q.size() == Depth) ovr_m = 1'b1;
        else exp_q.push_back(b);
    endtask

    task automatic m_reset();
        exp_q.delete();
        ovr_m  = 1'b0;
        frm_m  = 1'b0;
        ctrl_m = 3'b001;
    endtask

    task automatic check_pins(input string tag);
        int lvl = exp_q.size();
        check({tag, ".dreq"}, 32'(dreq), 32'(lvl != 0));
        check({tag, ".rts"}, 32'(rts), 32'(lvl >= Depth - 1));
        check({tag, ".irq"}, 32'(irq),
              32'((ctrl_m[1] && lvl != 0) || (ctrl_m[2] && (ovr_m || frm_m))));
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge clk); penable = 1'b1;
        #1 d = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(Cpb);
        end
        rx = stop_bit;
        idle(Cpb);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] d;
        logic [31:0] head;

        m_reset();
        #1 rst_n = 1'b0;
        idle(3);
        // Reset values
        check("rst.pready", 32'(pready), 32'd1);
        check("rst.pslverr", 32'(pslverr), 32'd0);
        check_pins("rst");
        check("rst.prdata", prdata, 32'h0);
        rst_n = 1'b1;
        idle(2);
        read_check("rst.ctrl", 16'h8, 32'h1);
        read_check("rst.stat", 16'h4, m_status());

        // 1: single frame with irq_en
        ctrl_m = 3'b011;
        apb_write(16'h8, 32'h3);
        check_pins("t1.pre");
        send_frame(8'hA5, 1'b1);
        m_push(8'hA5);
        check_pins("t1.rx");
        read_check("t1.stat", 16'h4, m_status());
        read_check("t1.data", 16'h0, m_pop());
        read_check("t1.data2", 16'h0, m_pop());
        read_check("t1.stat2", 16'h4, m_status());
        check_pins("t1.empty");
        ctrl_m = 3'b001;
        apb_write(16'h8, 32'h1);

        // 2: five random bytes, no reads, overrun on the fifth
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            m_push(b);
            check_pins($sformatf("t2.pins%0d", i));
            read_check($sformatf("t2.stat%0d", i), 16'h4, m_status());
        end
        for (int i = 0; i < 4; i++) read_check($sformatf("t2.data%0d", i), 16'h0, m_pop());
        apb_write(16'h4, 32'h4);
        ovr_m = 1'b0;
        read_check("t2.w1c", 16'h4, m_status());

        // 3: framing error with err_irq_en
        ctrl_m = 3'b101;
        apb_write(16'h8, 32'h5);
        send_frame(8'($urandom), 1'b0);
        frm_m = 1'b1;
        idle(Cpb);
        read_check("t3.stat", 16'h4, m_status());
        check_pins("t3.err");
        apb_write(16'h4, 32'h8);
        frm_m = 1'b0;
        check_pins("t3.w1c");
        read_check("t3.stat2", 16'h4, m_status());
        ctrl_m = 3'b001;
        apb_write(16'h8, 32'h1);

        // 4: 4-cycle glitch is rejected, then a clean frame
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * Cpb);
        read_check("t4.stat", 16'h4, m_status());
        read_check("t4.data", 16'h0, m_pop());
        send_frame(8'h3C, 1'b1);
        m_push(8'h3C);
        read_check("t4.data2", 16'h0, m_pop());

        // 5: fill, then pop in exactly the push cycle of a fifth byte
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            m_push(b);
        end
        read_check("t5.full", 16'h4, m_status());
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                idle(153);
                apb_read(16'h0, d);
            end
        join
        head = m_pop();
        check("t5.head", d, head);
        m_push(b);
        read_check("t5.stat", 16'h4, m_status());
        for (int i = 0; i < 4; i++) read_check($sformatf("t5.data%0d", i), 16'h0, m_pop());

        // 6: async reset in the middle of the data bits
        ctrl_m = 3'b011;
        apb_write(16'h8, 32'h3);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        m_push(b);
        check_pins("t6.pre");
        rx = 1'b0;
        idle(Cpb);
        rx = 1'b1;
        idle(Cpb);
        rx = 1'b0;
        idle(Cpb / 2);
        paddr = 16'h4;
        rst_n = 1'b0;
        rx = 1'b1;
        m_reset();
        #1;
        check("t6.pready", 32'(pready), 32'd1);
        check("t6.stat_rd", prdata, 32'h0);
        check_pins("t6.rst");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        read_check("t6.ctrl", 16'h8, 32'h1);
        read_check("t6.stat", 16'h4, m_status());
        send_frame(8'h66, 1'b1);
        m_push(8'h66);
        read_check("t6.data", 16'h0, m_pop());
        read_check("t6.stat2", 16'h4, m_status());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_mini_rx.md
# uart_mini_rx

Receive-side companion to the mini UART transmitter: an APB slave that deserialises 8N1 frames from the `rx` pin into a small byte FIFO. Software and DMA drain it through a memory-mapped data register. It sits on the same APB peripheral bus as the transmitter and shares the `SERIAL_WCNT` bit-period constant, so both ends run at the same baud rate.

## Interface
Parameters:
- `CLKS_PER_BIT`, default `` `SERIAL_WCNT ``: clk cycles per bit; legal values are ≥4.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `apbs_psel`, `apbs_penable`, `apbs_pwrite`  in  1 each  APB control.
- `apbs_paddr`  in  16  byte address; only bits [3:2] are decoded.
- `apbs_pwdata`  in  32  write data.
- `apbs_prdata`  out  32  read data.
- `apbs_pready`  out  1  tied to 1; there are no wait states.
- `apbs_pslverr`  out  1  tied to 0.
- `rx`  in  1  serial input, asynchronous, idle high.
- `rts`  out  1  1 = ask the far end to stop sending.
- `irq`  out  1  level interrupt.
- `dreq`  out  1  DMA request, equal to FIFO non-empty.

## Operation
Register map (offset):
- **0x0 RXDATA (RO):** [7:0] FIFO head, [8] valid; all bits read 0 when the FIFO is empty. An APB read access phase (psel & penable & !pwrite) with valid=1 pops one entry. A read of an empty FIFO has no side effect.
- **0x4 STATUS:**
  - [0] non-empty; [1] full.
  - [2] overrun (sticky); [3] framing error (sticky).
  - [7:4] level.
  - Writing 1 to [2] or [3] clears that bit. Other bits are RO.
- **0x8 CTRL (RW):**
  - [0] rx_en, reset 1.
  - [1] irq_en, reset 0.
  - [2] err_irq_en, reset 0.
- **0xC:** reads 0; writes are ignored.
- `apbs_prdata` is combinational from the decoded address.

Receive path:
- `rx` passes through a 2-flop synchroniser, reset value 1.
- States:
  - **IDLE:** wait until rx_en is set and a falling edge of the synchronised rx is seen.
  - **START:** count `CLKS_PER_BIT/2`, then sample. A 0 goes to DATA. A 1 is a glitch and returns to IDLE without setting any flag.
  - **DATA:** every `CLKS_PER_BIT` cycles, sample one bit into the shift register, LSB first. After 8 bits, go to STOP.
  - **STOP:** after `CLKS_PER_BIT`, sample.
    - A 1 pushes the byte. If the FIFO is full and there is no pop in the same cycle, the byte is dropped and overrun is set.
    - A 0 drops the byte and sets framing error.
    - Either way, return to IDLE. A new start needs a fresh falling edge, so a held-low line (break) produces exactly one framing error.
- Clearing rx_en forces IDLE immediately and discards any partial byte. The FIFO is kept.

Outputs:
- `irq` = (irq_en & non-empty) | (err_irq_en & (overrun | framing)).
- `rts` = 1 when level ≥ `FIFO_DEPTH`-1.

## Timing
- Every output, status bit and counter resets to 0, except:
  - `rts`: reset 0.
  - `apbs_pready`: 1 in reset.
  - synchroniser: reset 1.
  - rx_en: reset 1.
- Latency from pin to sampling point is 2 cycles of synchroniser delay plus the bit counter.
- The stop-bit sample pushes the byte on the next edge. non-empty, `dreq`, `irq` and level update the cycle after the push.
- A pop takes effect at the end of the access phase. The next read sees the new head.
- Push and pop in the same cycle:
  - level is unchanged.
  - When full, the push is accepted and overrun is not set.
- On a STATUS write in the same cycle a new error occurs, the set wins.
- Pointers wrap modulo `FIFO_DEPTH`. Level width is clog2(`FIFO_DEPTH`)+1.
- An asynchronous reset mid-frame returns to IDLE, empties the FIFO, and clears the flags.

## Structure
- Shared package / `define.vh`:
  - `SERIAL_WCNT`.
  - Register offsets `UART_RX_DATA`, `UART_RX_STAT`, `UART_RX_CTRL`.
  - Status/control bit indices.
  - FSM state encodings `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`.
- Sub-module `uart_rx_core`: synchroniser, FSM, bit/cycle counters. It outputs a one-cycle `byte_valid` with `byte_data`, and a one-cycle `frame_err` strobe.
- The top level holds the FIFO, the registers and the APB decode.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
1. Send frame 0xA5 → RXDATA reads 0x1A5. A second read returns 0x000. STATUS[0] goes 1→0. `dreq` follows.
2. Send 5 bytes 0x01..0x05 with no reads:
   - `rts` rises after the 3rd byte.
   - The 5th byte sets overrun.
   - Reads return 0x01..0x04.
   - Writing 0x4 to STATUS clears overrun.
3. Send a frame with the stop bit = 0 → framing=1 and the FIFO stays empty. With err_irq_en=1, `irq`=1 until W1C.
4. Pulse `rx` low for 4 cycles → no byte and no flags; the FSM is back in IDLE. A following 0x3C is received correctly.
5. Fill the FIFO to 4, then time an RXDATA read to land in the stop-bit push cycle → level stays 4, no overrun, and the new byte is last in order.
6. Assert `rst_n` low mid-DATA of byte 0x55 → all outputs are at reset values. The next frame 0x66 is received intact.
